rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
- Downstream LED output stage for the Arty blinky designs.
- Replaces the fixed 12.5% duty gating with per-channel 8-bit brightness PWM on the 12 RGB LED lines (4 LEDs x R,G,B).
- Upstream control logic, such as the counter/colour sequencer, writes duty values into a pending bank through a valid/ready port, then requests a commit.
- The commit is applied only at a PWM period boundary, so LEDs never glitch mid-period.

Parameters:
- CHANNELS, 12, number of PWM outputs.
- PWM_WIDTH, 8, duty and PWM counter width.
- PRESCALE, 4, clk cycles per PWM tick. Must be >= 1. Default gives 65MHz/4/255 ≈ 63.7kHz PWM.

Ports:
- clk  input  1  65MHz system clock (BUFG-driven CFGMCLK).
- rstN  input  1  asynchronous active-low reset.
- duty_valid  input  1  duty write request.
- duty_ready  output  1  pending bank can accept a write.
- duty_index  input  $clog2(CHANNELS)  channel to write.
- duty_value  input  PWM_WIDTH  duty for that channel.
- commit  input  1  single-cycle pulse; copy pending bank to active bank at next period boundary.
- commit_busy  output  1  commit armed, not yet applied.
- period_start  output  1  single-cycle pulse on the first clk of each PWM period.
- pwm_out  output  CHANNELS  registered PWM outputs (1 = LED on).

Behaviour:
- Reset (rstN low, async):
  - Pending and active banks = 0; pwm_out = 0; period_start = 0; commit_busy = 0; duty_ready = 1.
  - Prescaler and PWM counter = 0; FSM = IDLE.
  - Reset asserted mid-commit discards the armed commit.
- Prescaler: counts 0..PRESCALE-1. tick = 1 when count == PRESCALE-1, then wraps to 0. PRESCALE=1 gives tick every cycle.
- PWM counter pwm_cnt: advances on tick through 0..2^PWM_WIDTH-2, i.e. 0..254 with a 255-tick period, then wraps to 0.
- boundary = tick && pwm_cnt == 2^PWM_WIDTH-2.
- Output rule, registered with 1-clk latency from counter state: pwm_out[i] <= (pwm_cnt < active[i]).
  - duty 0 = always off.
  - duty 255 = always on.
  - duty N = on for N of 255 ticks.
- period_start <= boundary. It is asserted for 1 clk coinciding with pwm_cnt == 0 after the wrap.
- Write handshake:
  - Write occurs when duty_valid && duty_ready; pending[duty_index] <= duty_value.
  - duty_index >= CHANNELS: the handshake completes but the data is discarded.
  - duty_ready = !commit_busy, so writes stall while a commit is armed.
- Commit FSM:
  - IDLE: commit -> ARMED, commit_busy = 1 from the next clk.
  - ARMED: on boundary, active <= pending (all channels in the same clk), then -> IDLE, commit_busy = 0 the following clk.
  - Further commit pulses in ARMED are ignored.
  - commit and boundary in the same clk while IDLE: enter ARMED; the copy happens at the following boundary, not this one.
- Active bank changes only at boundary. New duties take effect from the first pwm_out update of the new period.
- Wrap-around: all counters are modulo as stated; no saturation; no overflow states.

Decomposition:
- Package rgb_pwm_pkg:
  - state_t enum {IDLE, ARMED}.
  - PWM_MAX = 2^PWM_WIDTH-2 expressed as a function of width.
  - Default CHANNELS/PWM_WIDTH constants.
- Sub-module pwm_tick_gen (prescaler plus PWM counter; outputs tick, pwm_cnt, boundary).
- Banks, handshake, FSM and output compare stay in rgb_pwm_driver.

Test Plan (bench uses PRESCALE=1 unless noted):
- Reset:
  - Stimulus: hold rstN low 10 clk, release.
  - Required: pwm_out=0, duty_ready=1, commit_busy=0.
  - Required: first period_start exactly 255 clk after release.
- Basic duty:
  - Stimulus: write ch0=0, ch1=1, ch2=128, ch3=255, then commit.
  - Required: after the boundary, per 255-clk period ch0 high 0 clk, ch1 1 clk, ch2 128 clk, ch3 255 clk.
  - Required: ch1 high only in the cycle after period_start.
- Glitch-free commit:
  - Stimulus: ch0 active=200; write ch0=10 and commit at pwm_cnt=50.
  - Required: the current period still shows 200 high clk; the next period shows 10.
  - Required: commit_busy high from commit+1 until boundary+1.
- Handshake stall:
  - Stimulus: hold duty_valid with index 5 = 99 while commit_busy=1.
  - Required: duty_ready=0, no write until the boundary.
  - Required: the write completes 1 clk after commit_busy falls; pending[5]=99.
- Edge cases:
  - Stimulus: write index 13 (=0x0D, out of range) = 77.
  - Required: accepted; no channel changes.
  - Stimulus: commit in the same clk as boundary.
  - Required: applied one full period later.
  - Stimulus: rstN pulse while ARMED.
  - Required: commit discarded, all outputs back to reset values.
- Prescaler:
  - Stimulus: PRESCALE=4, ch0=128.
  - Required: period_start spacing 1020 clk; ch0 high 512 clk per period.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared types and constants for the RGB LED PWM output stage.
//   state_t      : commit FSM encoding (IDLE / ARMED)
//   pwm_max()    : last PWM counter value for a given counter width
//   *_DEF        : default geometry (4 LEDs x R,G,B, 8-bit duty, /4 prescale)
// -----------------------------------------------------------------------------
package rgb_pwm_pkg;

    localparam int CHANNELS_DEF  = 12;
    localparam int PWM_WIDTH_DEF = 8;
    localparam int PRESCALE_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // The counter stops one short of all-ones so that a duty of all-ones
    // compares true on every tick of the period, i.e. fully on.
    function automatic int pwm_max(input int width);
        return (1 << width) - 2;
    endfunction

    localparam int PWM_MAX_DEF = pwm_max(PWM_WIDTH_DEF);

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Prescaler plus PWM period counter.
//   clk       in   system clock
//   rstN      in   asynchronous active-low reset
//   tick      out  one clk every PRESCALE clks (every clk when PRESCALE = 1)
//   pwm_cnt   out  PWM counter, advances on tick through 0..pwm_max(PWM_WIDTH)
//   boundary  out  tick on the last counter value: the period ends this clk
// -----------------------------------------------------------------------------
module pwm_tick_gen
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = PWM_WIDTH_DEF,
    parameter int PRESCALE  = PRESCALE_DEF
) (
    input  logic                 clk,
    input  logic                 rstN,
    output logic                 tick,
    output logic [PWM_WIDTH-1:0] pwm_cnt,
    output logic                 boundary
);

    // A one-bit prescaler is kept for PRESCALE = 1; it simply never leaves 0.
    localparam int                     PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]        PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0]   CNT_LAST = PWM_WIDTH'(pwm_max(PWM_WIDTH));

    logic [PS_W-1:0] presc_cnt;

    assign tick     = (presc_cnt == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            if (tick) begin
                if (pwm_cnt == CNT_LAST) begin
                    pwm_cnt <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
// Per-channel brightness PWM for the 12 RGB LED lines (4 LEDs x R,G,B).
// Duties are written into a pending bank and copied to the active bank only
// at a PWM period boundary, so an LED never changes mid-period.
//   clk           in   65 MHz system clock
//   rstN          in   asynchronous active-low reset
//   duty_valid    in   duty write request
//   duty_ready    out  pending bank can accept a write (low while commit armed)
//   duty_index    in   channel to write; out-of-range indices are accepted
//                      and dropped
//   duty_value    in   duty for that channel (0 = off, all-ones = always on)
//   commit        in   pulse: copy pending -> active at the next boundary
//   commit_busy   out  commit armed, not yet applied
//   period_start  out  one-clk pulse on the first clk of each PWM period
//   pwm_out       out  registered PWM outputs, 1 = LED on
// -----------------------------------------------------------------------------
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int PWM_WIDTH = PWM_WIDTH_DEF,
    parameter int PRESCALE  = PRESCALE_DEF
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        duty_valid,
    output logic                        duty_ready,
    input  logic [$clog2(CHANNELS)-1:0] duty_index,
    input  logic [PWM_WIDTH-1:0]        duty_value,
    input  logic                        commit,
    output logic                        commit_busy,
    output logic                        period_start,
    output logic [CHANNELS-1:0]         pwm_out
);

    logic [PWM_WIDTH-1:0] pending [CHANNELS];
    logic [PWM_WIDTH-1:0] active  [CHANNELS];

    state_t               state;
    logic                 wr_en;

    logic                 tick_unused;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 boundary;

    logic [CHANNELS-1:0]  pwm_cmp_p0;
    logic [CHANNELS-1:0]  pwm_out_p1;
    logic                 period_start_p1;

    // The driver only needs the period boundary; the raw tick stays available
    // on the sub-module for other consumers.
    pwm_tick_gen #(
        .PWM_WIDTH (PWM_WIDTH),
        .PRESCALE  (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .rstN     (rstN),
        .tick     (tick_unused),
        .pwm_cnt  (pwm_cnt),
        .boundary (boundary)
    );

    // Writes stall while a commit is armed so the bank being copied at the
    // boundary is exactly the one the upstream logic committed.
    assign duty_ready  = (state == IDLE);
    assign commit_busy = (state == ARMED);
    assign wr_en       = duty_valid && duty_ready && (int'(duty_index) < CHANNELS);

    // ---- pending bank ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
            end
        end else if (wr_en) begin
            pending[duty_index] <= duty_value;
        end
    end

    // ---- commit FSM ----
    // A commit arriving in the boundary clk itself only arms; the copy waits
    // for the next boundary, which keeps the rule "copy only while ARMED".
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (boundary) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- active bank, all channels swap in the same clk ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else if ((state == ARMED) && boundary) begin
            active <= pending;
        end
    end

    // ---- stage p0: compare counter against active duty ----
    always_comb begin
        pwm_cmp_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_cmp_p0[i] = (pwm_cnt < active[i]);
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pwm_out_p1      <= '0;
            period_start_p1 <= 1'b0;
        end else begin
            pwm_out_p1      <= pwm_cmp_p0;
            period_start_p1 <= boundary;
        end
    end

    assign pwm_out      = pwm_out_p1;
    assign period_start = period_start_p1;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_driver
// Directed bench for rgb_pwm_driver: PRESCALE = 1 instance for most checks,
// a second PRESCALE = 4 instance for the prescaler timing.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_driver;

    localparam int CH = 12;

    typedef struct {
        int idx;
        int val;
        int exp_hi;
    } vec_t;

    logic          clk;
    logic          rstN;
    logic          duty_valid;
    logic          duty_ready;
    logic [3:0]    duty_index;
    logic [7:0]    duty_value;
    logic          commit;
    logic          commit_busy;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    logic          rstN4;
    logic          duty_valid4;
    logic          duty_ready4;
    logic [3:0]    duty_index4;
    logic [7:0]    duty_value4;
    logic          commit4;
    logic          commit_busy4;
    logic          period_start4;
    logic [CH-1:0] pwm_out4;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pend [CH];
    int exp_act  [CH];
    int hi_cnt   [CH];
    int first1;
    int ps_mid;
    vec_t vecs [6];

    rgb_pwm_driver #(.CHANNELS(CH), .PWM_WIDTH(8), .PRESCALE(1)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .duty_index   (duty_index),
        .duty_value   (duty_value),
        .commit       (commit),
        .commit_busy  (commit_busy),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    rgb_pwm_driver #(.CHANNELS(CH), .PWM_WIDTH(8), .PRESCALE(4)) dut4 (
        .clk          (clk),
        .rstN         (rstN4),
        .duty_valid   (duty_valid4),
        .duty_ready   (duty_ready4),
        .duty_index   (duty_index4),
        .duty_value   (duty_value4),
        .commit       (commit4),
        .commit_busy  (commit_busy4),
        .period_start (period_start4),
        .pwm_out      (pwm_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic write_duty(input int idx, input int val);
        int n;
        logic [3:0] i4;
        logic [7:0] v8;
        n  = 0;
        i4 = idx[3:0];
        v8 = val[7:0];
        duty_valid = 1'b1;
        duty_index = i4;
        duty_value = v8;
        while (!duty_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!duty_ready) check("write_timeout", 0, 1);
        @(negedge clk);
        duty_valid = 1'b0;
        if (idx < CH) exp_pend[idx] = val;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Leaves the bench on the period_start clk in which the commit took effect.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (commit_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_falls_on_period_start"}, int'(period_start), 1);
    endtask

    task automatic wait_ps(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (period_start) break;
        end
    endtask

    // Called on a period_start clk; samples the next 255 clks (counter 0..254).
    task automatic measure_period();
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        first1 = -1;
        ps_mid = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (pwm_out[1] && first1 < 0) first1 = i;
            if (i < 255 && period_start) ps_mid++;
        end
    endtask

    task automatic compare_all(input string name);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s_ch%0d_high", name, c), hi_cnt[c], exp_act[c]);
    endtask

    initial begin
        int n, hi_a, hi_b, cnt;

        vecs[0] = '{0, 0, 0};
        vecs[1] = '{1, 1, 1};
        vecs[2] = '{2, 128, 128};
        vecs[3] = '{3, 255, 255};
        vecs[4] = '{4, 254, 254};
        vecs[5] = '{6, 17, 17};

        for (int c = 0; c < CH; c++) begin
            exp_pend[c] = 0;
            exp_act[c]  = 0;
        end

        rstN = 1'b0;  duty_valid = 1'b0;  duty_index = '0;  duty_value = '0;  commit = 1'b0;
        rstN4 = 1'b0; duty_valid4 = 1'b0; duty_index4 = '0; duty_value4 = '0; commit4 = 1'b0;

        // Reset
        repeat (10) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_duty_ready", int'(duty_ready), 1);
        check("rst_commit_busy", int'(commit_busy), 0);
        check("rst_period_start", int'(period_start), 0);
        rstN  = 1'b1;
        rstN4 = 1'b1;
        wait_ps(300, n);
        check("rst_first_period_start_clk", n, 255);
        check("rst_pwm_out_after", int'(pwm_out), 0);

        // Basic duty, table driven
        for (int k = 0; k < 6; k++) write_duty(vecs[k].idx, vecs[k].val);
        commit_pulse();
        wait_idle("basic");
        exp_act = exp_pend;
        measure_period();
        for (int k = 0; k < 6; k++)
            check($sformatf("basic_ch%0d_high", vecs[k].idx), hi_cnt[vecs[k].idx], vecs[k].exp_hi);
        check("basic_ch1_first_high_clk", first1, 1);
        check("basic_no_mid_period_start", ps_mid, 0);

        // Glitch-free commit: ch0 = 200, then write 10 and commit at pwm_cnt = 50
        write_duty(0, 200);
        commit_pulse();
        wait_idle("glitch_pre");
        exp_act = exp_pend;
        hi_a = 0; hi_b = 0; cnt = 0;
        for (int i = 1; i <= 510; i++) begin
            @(negedge clk);
            if (i <= 255) begin
                if (pwm_out[0]) hi_a++;
                if (commit_busy) cnt++;
            end else if (pwm_out[0]) begin
                hi_b++;
            end
            if (i == 50)  check("glitch_busy_at_commit", int'(commit_busy), 0);
            if (i == 51)  check("glitch_busy_commit_plus1", int'(commit_busy), 1);
            if (i == 254) check("glitch_busy_at_boundary", int'(commit_busy), 1);
            if (i == 255) begin
                check("glitch_busy_boundary_plus1", int'(commit_busy), 0);
                check("glitch_period_start", int'(period_start), 1);
            end
            if (i == 49) begin duty_valid = 1'b1; duty_index = 4'd0; duty_value = 8'd10; end
            if (i == 50) begin duty_valid = 1'b0; commit = 1'b1; end
            if (i == 51) commit = 1'b0;
        end
        exp_pend[0] = 10;
        exp_act[0]  = 10;
        check("glitch_old_period_high", hi_a, 200);
        check("glitch_busy_clks", cnt, 204);
        check("glitch_new_period_high", hi_b, 10);

        // Handshake stall: write ch5 = 99 held while commit armed
        cnt = 0; hi_b = 0;
        for (int i = 1; i <= 510; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 254 && !duty_ready) cnt++;
            if (i == 2)   check("stall_ready_low", int'(duty_ready), 0);
            if (i == 255) check("stall_ready_after_boundary", int'(duty_ready), 1);
            if (i >= 256 && pwm_out[5]) hi_b++;
            if (i == 1) commit = 1'b1;
            if (i == 2) begin commit = 1'b0; duty_valid = 1'b1; duty_index = 4'd5; duty_value = 8'd99; end
            if (i == 256) duty_valid = 1'b0;
        end
        check("stall_ready_low_clks", cnt, 253);
        check("stall_ch5_not_committed", hi_b, 0);
        exp_pend[5] = 99;
        commit_pulse();
        wait_idle("stall");
        exp_act = exp_pend;
        measure_period();
        compare_all("stall");

        // Out-of-range index is accepted and dropped
        check("oor_ready", int'(duty_ready), 1);
        write_duty(13, 77);
        commit_pulse();
        wait_idle("oor");
        exp_act = exp_pend;
        measure_period();
        compare_all("oor");

        // Commit in the boundary clk applies one full period later
        write_duty(0, 33);
        hi_a = 0; hi_b = 0;
        for (int i = 2; i <= 765; i++) begin
            @(negedge clk);
            if (i >= 256 && i <= 510 && pwm_out[0]) hi_a++;
            if (i >= 511 && pwm_out[0]) hi_b++;
            if (i == 255) check("same_clk_busy_armed", int'(commit_busy), 1);
            if (i == 509) check("same_clk_busy_next_boundary", int'(commit_busy), 1);
            if (i == 510) begin
                check("same_clk_busy_cleared", int'(commit_busy), 0);
                check("same_clk_period_start", int'(period_start), 1);
            end
            if (i == 254) commit = 1'b1;
            if (i == 255) commit = 1'b0;
        end
        exp_act[0] = 33;
        check("same_clk_old_duty_kept", hi_a, 10);
        check("same_clk_new_duty", hi_b, 33);

        // Reset pulse while ARMED
        write_duty(2, 5);
        commit_pulse();
        check("rst_armed_busy", int'(commit_busy), 1);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        check("rst_armed_pwm_out", int'(pwm_out), 0);
        check("rst_armed_ready", int'(duty_ready), 1);
        check("rst_armed_busy_cleared", int'(commit_busy), 0);
        check("rst_armed_period_start", int'(period_start), 0);
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < CH; c++) begin
            exp_pend[c] = 0;
            exp_act[c]  = 0;
        end
        wait_ps(300, n);
        check("rst_armed_first_period_start_clk", n, 255);
        measure_period();
        compare_all("rst_armed_active");
        commit_pulse();
        wait_idle("rst_pend");
        measure_period();
        compare_all("rst_armed_pending");

        // Prescaler = 4, ch0 = 128
        check("ps4_ready", int'(duty_ready4), 1);
        duty_valid4 = 1'b1; duty_index4 = 4'd0; duty_value4 = 8'd128;
        @(negedge clk);
        duty_valid4 = 1'b0;
        commit4 = 1'b1;
        @(negedge clk);
        commit4 = 1'b0;
        n = 0;
        while (commit_busy4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ps4_busy_falls_on_period_start", int'(period_start4), 1);
        hi_a = 0; cnt = 0;
        for (int i = 1; i <= 1020; i++) begin
            @(negedge clk);
            if (pwm_out4[0]) hi_a++;
            if (i < 1020 && period_start4) cnt++;
            if (i == 1020) check("ps4_period_spacing", int'(period_start4), 1);
        end
        check("ps4_no_mid_period_start", cnt, 0);
        check("ps4_ch0_high", hi_a, 512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
